gfx_fb_mem_arbiter: RTL and testbench

//  Shares one framebuffer memory command port between the display read stream and the gfx pixel writer.

---
 rtl/gfx_fb_mem_arbiter.sv | 115 +++++++++++
 tb/tb_gfx_fb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_fb_mem_arbiter.sv
// gfx_fb_mem_arbiter: shares one framebuffer memory command port between display reads and gfx writes,
// with display credit tracking, read/write turnaround bubbles and gfx starvation reporting.
module gfx_fb_mem_arbiter #(
   parameter int ADDR_WIDTH   = 10,
   parameter int DATA_WIDTH   = 16,
   parameter int FIFO_DEPTH   = 16,
   parameter int LOW_WATER    = 4,
   parameter int TURNAROUND   = 1,
   parameter int MAX_GFX_WAIT = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  disp_valid,
   input  logic [ADDR_WIDTH-1:0] disp_addr,
   output logic                  disp_ready,
   input  logic                  disp_pop,
   output logic                  disp_rd_valid,
   output logic [DATA_WIDTH-1:0] disp_rd_data,
   input  logic                  gfx_valid,
   input  logic [ADDR_WIDTH-1:0] gfx_addr,
   input  logic [DATA_WIDTH-1:0] gfx_data,
   output logic                  gfx_ready,
   output logic                  mem_cmd_valid,
   input  logic                  mem_cmd_ready,
   output logic                  mem_cmd_we,
   output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
   output logic [DATA_WIDTH-1:0] mem_cmd_wdata,
   input  logic                  mem_rd_valid,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  gfx_starve
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int WW = $clog2(MAX_GFX_WAIT);
   localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] LW = CW'(LOW_WATER);
   localparam logic [WW-1:0] WMAX = WW'(MAX_GFX_WAIT - 1);
   localparam logic [1:0] TA_M1 = 2'(TURNAROUND > 0 ? TURNAROUND - 1 : 0);

   typedef enum logic {ARB, TURN} state_t;
   state_t state, state_n;

   logic [CW-1:0] credits, inflight;
   logic [WW-1:0] gfx_wait;
   logic [1:0]    tcnt;
   // Direction/grant encoding: 1 = gfx write, 0 = display read
   logic last_dir, last_grant, pend_dir, starved;
   logic disp_el, urgent, pick_disp, pick_gfx, sw, g_disp, g_gfx, rd_ok, pop_ok, blocked;

   // The cycle that detects a direction change is the first bubble cycle; TURN covers the rest
   // and then issues the committed direction without re-arbitrating.
   always_comb begin
      disp_el   = disp_valid && credits != '0;
      urgent    = (DEPTH - credits) < LW;
      pick_disp = disp_el && (urgent || !gfx_valid || last_grant);
      pick_gfx  = gfx_valid && !pick_disp;
      sw        = state == ARB && (pick_disp || pick_gfx) && pick_gfx != last_dir && TURNAROUND > 0;
      g_disp    = 1'b0;
      g_gfx     = 1'b0;
      state_n   = state;
      if (state == ARB) begin
         g_disp  = reset && pick_disp && !sw;
         g_gfx   = reset && pick_gfx && !sw;
         state_n = sw ? TURN : ARB;
      end else if (tcnt == '0) begin
         g_disp  = reset && !pend_dir && disp_el;
         g_gfx   = reset && pend_dir && gfx_valid;
         state_n = (!(g_disp || g_gfx) || mem_cmd_ready) ? ARB : TURN;
      end
   end

   assign mem_cmd_valid = g_disp || g_gfx;
   assign mem_cmd_we    = g_gfx;
   assign mem_cmd_addr  = g_gfx ? gfx_addr : g_disp ? disp_addr : '0;
   assign mem_cmd_wdata = g_gfx ? gfx_data : '0;
   assign disp_ready    = g_disp && mem_cmd_ready;
   assign gfx_ready     = g_gfx && mem_cmd_ready;
   assign rd_ok         = mem_rd_valid && inflight != '0;
   assign pop_ok        = disp_pop && credits != DEPTH;
   assign blocked       = gfx_valid && !gfx_ready;
   assign gfx_starve    = blocked && gfx_wait == WMAX && !starved;

   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= ARB;
      else state <= state_n;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         credits       <= DEPTH;
         inflight      <= '0;
         last_dir      <= 1'b0;
         last_grant    <= 1'b1;
         pend_dir      <= 1'b0;
         tcnt          <= '0;
         gfx_wait      <= '0;
         starved       <= 1'b0;
         disp_rd_valid <= 1'b0;
         disp_rd_data  <= '0;
      end else begin
         credits       <= credits - CW'(disp_ready) + CW'(pop_ok);
         inflight      <= inflight + CW'(disp_ready) - CW'(rd_ok);
         disp_rd_valid <= rd_ok;
         disp_rd_data  <= rd_ok ? mem_rd_data : '0;
         if (sw) begin
            pend_dir <= pick_gfx;
            last_dir <= pick_gfx;
            tcnt     <= TA_M1;
         end else if (state == TURN && tcnt != '0) tcnt <= tcnt - 2'd1;
         if (mem_cmd_valid && mem_cmd_ready) begin
            last_dir   <= g_gfx;
            last_grant <= g_gfx;
         end
         gfx_wait <= !blocked ? '0 : gfx_wait == WMAX ? gfx_wait : gfx_wait + WW'(1);
         starved  <= blocked && (starved || gfx_starve);
      end
endmodule

// File: tb/tb_gfx_fb_mem_arbiter.sv
// tb_gfx_fb_mem_arbiter: vector table, directed corner sequences and a randomized run
// against a behavioural model of the arbitration rules.
module tb_gfx_fb_mem_arbiter;
   localparam int AW = 10, DW = 16, DEPTH = 16, LOWW = 4, TA = 1, MAXW = 64;

   logic clk = 1'b0, reset = 1'b0;
   logic disp_valid, disp_ready, disp_pop, disp_rd_valid;
   logic [AW-1:0] disp_addr, gfx_addr, mem_cmd_addr;
   logic [DW-1:0] disp_rd_data, gfx_data, mem_cmd_wdata, mem_rd_data;
   logic gfx_valid, gfx_ready, mem_cmd_valid, mem_cmd_ready, mem_cmd_we, mem_rd_valid, gfx_starve;
   logic [47:0] outs;

   always #5 clk = ~clk;

   gfx_fb_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .LOW_WATER(LOWW),
                        .TURNAROUND(TA), .MAX_GFX_WAIT(MAXW)) dut (
      .clk(clk), .reset(reset), .disp_valid(disp_valid), .disp_addr(disp_addr), .disp_ready(disp_ready),
      .disp_pop(disp_pop), .disp_rd_valid(disp_rd_valid), .disp_rd_data(disp_rd_data),
      .gfx_valid(gfx_valid), .gfx_addr(gfx_addr), .gfx_data(gfx_data), .gfx_ready(gfx_ready),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
      .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata), .mem_rd_valid(mem_rd_valid),
      .mem_rd_data(mem_rd_data), .gfx_starve(gfx_starve));

   assign outs = {mem_cmd_valid, mem_cmd_we, disp_ready, gfx_ready, gfx_starve, disp_rd_valid,
                  mem_cmd_addr, mem_cmd_wdata, disp_rd_data};

   int n_tests = 0, n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      disp_valid = 0; disp_addr = '0; disp_pop = 0; gfx_valid = 0; gfx_addr = '0; gfx_data = '0;
      mem_cmd_ready = 1; mem_rd_valid = 0; mem_rd_data = '0;
   endtask

   task automatic do_reset();
      reset = 0;
      idle_inputs();
      tick();
      tick();
      check("reset_outputs", 64'(outs), 64'd0);
      reset = 1;
   endtask

   task automatic count_reads(input int cycles, output int n);
      n = 0;
      for (int c = 0; c < cycles; c++) begin
         #2;
         if (disp_ready) n++;
         tick();
      end
   endtask

   // Behavioural model: integer credit/occupancy bookkeeping plus the arbitration rules
   int m_cred, m_infl, m_occ, m_wait, m_bubble;
   bit m_last_wr, m_last_gfx, m_pend, m_pend_wr, m_starved, m_sw, m_sw_wr, m_rdv;
   bit e_valid, e_we, e_dr, e_gr, e_starve;
   logic [DW-1:0] m_rdd;

   task automatic model_reset();
      m_cred = DEPTH; m_infl = 0; m_occ = 0; m_wait = 0; m_bubble = 0;
      m_last_wr = 0; m_last_gfx = 1; m_pend = 0; m_pend_wr = 0; m_starved = 0; m_rdv = 0; m_rdd = '0;
   endtask

   task automatic model_eval();
      bit del, want_d, want_g;
      del = disp_valid && m_cred > 0;
      want_d = 0; want_g = 0; m_sw = 0;
      if (m_pend) begin
         if (m_bubble == 0) begin
            want_d = !m_pend_wr && del;
            want_g = m_pend_wr && gfx_valid;
         end
      end else begin
         if (del && ((DEPTH - m_cred) < LOWW || !gfx_valid || m_last_gfx)) want_d = 1;
         else want_g = gfx_valid;
         if ((want_d || want_g) && want_g != m_last_wr && TA > 0) begin
            m_sw = 1; m_sw_wr = want_g; want_d = 0; want_g = 0;
         end
      end
      e_valid = want_d || want_g;
      e_we = want_g;
      e_dr = want_d && mem_cmd_ready;
      e_gr = want_g && mem_cmd_ready;
      e_starve = gfx_valid && !e_gr && m_wait == MAXW - 1 && !m_starved;
   endtask

   task automatic model_update();
      bit ret, pop;
      ret = mem_rd_valid && m_infl > 0;
      pop = disp_pop && m_cred < DEPTH;
      if (m_sw) begin
         m_pend = 1; m_pend_wr = m_sw_wr; m_bubble = TA - 1; m_last_wr = m_sw_wr;
      end else if (m_pend) begin
         if (m_bubble > 0) m_bubble--;
         else if (!e_valid || mem_cmd_ready) m_pend = 0;
      end
      if (e_dr || e_gr) begin m_last_wr = e_gr; m_last_gfx = e_gr; end
      m_cred = m_cred - int'(e_dr) + int'(pop);
      m_infl = m_infl + int'(e_dr) - int'(ret);
      m_occ = m_occ + int'(ret) - int'(disp_pop);
      m_rdv = ret;
      m_rdd = ret ? mem_rd_data : '0;
      if (gfx_valid && !e_gr) begin
         if (e_starve) m_starved = 1;
         if (m_wait < MAXW - 1) m_wait++;
      end else begin
         m_wait = 0; m_starved = 0;
      end
   endtask

   typedef struct packed {
      logic dv, gv, rdy, ev, ewe, edr, egr;
   } vec_t;
   vec_t tbl[15];

   initial begin
      int n, n1, n2, pulses, at;
      logic [47:0] exp;
      tbl = '{7'b111_1010, 7'b111_1010, 7'b111_1010, 7'b111_1010, 7'b111_0000,
              7'b111_1101, 7'b111_0000, 7'b111_1010, 7'b111_0000, 7'b110_1100,
              7'b111_1101, 7'b011_1101, 7'b101_0000, 7'b101_1010, 7'b001_0000};

      // Vector table from reset: urgent reads, then alternating R/W with one bubble per switch
      do_reset();
      disp_addr = 10'h011; gfx_addr = 10'h222; gfx_data = 16'hBEEF;
      for (int i = 0; i < 15; i++) begin
         disp_valid = tbl[i].dv; gfx_valid = tbl[i].gv; mem_cmd_ready = tbl[i].rdy;
         #2;
         exp = {tbl[i].ev, tbl[i].ewe, tbl[i].edr, tbl[i].egr, 1'b0, 1'b0,
                tbl[i].ev ? (tbl[i].ewe ? 10'h222 : 10'h011) : 10'h000,
                (tbl[i].ev && tbl[i].ewe) ? 16'hBEEF : 16'h0000, 16'h0000};
         check($sformatf("vec%0d", i), 64'(outs), 64'(exp));
         tick();
      end

      // Credit exhaustion and single-credit return
      do_reset();
      disp_valid = 1; disp_addr = 10'h3A5;
      count_reads(24, n);
      check("t1_reads_until_empty", 64'(n), 64'd16);
      #2;
      check("t1_stalled", 64'({disp_ready, mem_cmd_valid}), 64'd0);
      tick();
      disp_pop = 1;
      count_reads(1, n1);
      disp_pop = 0;
      count_reads(6, n2);
      check("t1_one_more_read", 64'(n1 + n2), 64'd1);

      // Memory back-pressure with a gfx write pending
      do_reset();
      gfx_valid = 1; gfx_addr = 10'h155; gfx_data = 16'hA5C3; mem_cmd_ready = 0;
      #2;
      check("t4_bubble", 64'(mem_cmd_valid), 64'd0);
      tick();
      for (int c = 0; c < 5; c++) begin
         #2;
         check("t4_stall", 64'({mem_cmd_valid, mem_cmd_we, gfx_ready, disp_ready, mem_cmd_addr, mem_cmd_wdata}),
               64'({4'b1100, 10'h155, 16'hA5C3}));
         tick();
      end
      mem_cmd_ready = 1;
      #2;
      check("t4_accept", 64'(gfx_ready), 64'd1);
      tick();
      gfx_valid = 0; disp_valid = 1;
      count_reads(24, n);
      check("t4_credits_intact", 64'(n), 64'd16);

      // Starvation: gfx blocked by an urgent display for 80 cycles
      do_reset();
      disp_valid = 1; gfx_valid = 1; disp_pop = 1; mem_rd_valid = 1;
      pulses = 0; at = -1;
      for (int c = 0; c < 80; c++) begin
         #2;
         if (gfx_starve) begin pulses++; at = c; end
         if (gfx_ready) check("t5_gfx_blocked", 64'(gfx_ready), 64'd0);
         tick();
      end
      check("t5_pulse_count", 64'(pulses), 64'd1);
      check("t5_pulse_cycle", 64'(at), 64'd63);

      // Reset with reads in flight
      do_reset();
      disp_valid = 1;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) begin mem_rd_valid = 1; mem_rd_data = 16'h1234; end
         tick();
      end
      mem_rd_valid = 0; gfx_valid = 1;
      #2;
      check("t6_rd_forward", 64'({disp_rd_valid, disp_rd_data}), 64'({1'b1, 16'h1234}));
      reset = 0;
      mem_rd_valid = 1; mem_rd_data = 16'h5555;
      #1;
      check("t6_reset_async", 64'(outs), 64'd0);
      tick();
      tick();
      check("t6_reset_held", 64'(outs), 64'd0);
      reset = 1; disp_valid = 0; gfx_valid = 0;
      tick();
      mem_rd_valid = 0;
      #2;
      check("t6_inflight_cleared", 64'(disp_rd_valid), 64'd0);
      tick();
      disp_valid = 1;
      count_reads(24, n);
      check("t6_credits_restored", 64'(n), 64'd16);

      // Randomized run against the model
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         disp_valid = $urandom_range(0, 3) != 0;
         gfx_valid = $urandom_range(0, 2) != 0;
         mem_cmd_ready = $urandom_range(0, 4) != 0;
         disp_pop = m_occ > 0 && $urandom_range(0, 1) == 1;
         mem_rd_valid = m_infl > 0 && $urandom_range(0, 2) != 0;
         disp_addr = AW'($urandom); gfx_addr = AW'($urandom);
         gfx_data = DW'($urandom); mem_rd_data = DW'($urandom);
         #2;
         model_eval();
         exp = {e_valid, e_we, e_dr, e_gr, e_starve, m_rdv,
                e_valid ? (e_we ? gfx_addr : disp_addr) : '0, (e_valid && e_we) ? gfx_data : '0, m_rdd};
         check($sformatf("rand%0d", c), 64'(outs), 64'(exp));
         model_update();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
